fios_res_collector: RTL

- Downstream stage of the FIOS Montgomery multiplier (NOCASC variant).
- Captures the s 17-bit result words that the multiplier pushes serially, least-significant word first.
- Assembles them into one s*17-bit operand and presents it to the consumer with a valid/ready handshake.
- Optionally performs the final Montgomery conditional subtraction (R >= p ? R-p : R) on the fly, as the words arrive.

---
 rtl/fios_res_collector.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fios_res_collector.sv
// ---------------------------------------------------------------------------
// fios_res_collector
//
// Downstream stage of the FIOS Montgomery multiplier (NOCASC variant).
// Captures s 17-bit result words pushed serially (least-significant first),
// assembles them into one s*17-bit operand and presents it with valid/ready.
//
// Optional feature (macro FIOS_RES_SUB_EN): the final Montgomery conditional
// subtraction R >= p ? R-p : R is computed word by word as results arrive.
//
// Handshake: res_o is offered while res_valid_o is high and is held stable
// until the cycle where res_valid_o && res_ready_i, which is the transfer.
//
// Ports:
//   clock_i      rising-edge clock
//   reset_i      synchronous active-high reset
//   start_i      arm for a new result (restarts an ongoing collection)
//   RES_push_i   one pulse per result word, RES_i valid in that cycle
//   RES_i        17-bit result word
//   done_i       end-of-result marker from the multiplier
//   p_i          modulus (word k at [17k+16:17k]), used with FIOS_RES_SUB_EN
//   res_o        assembled result (word k at [17k+16:17k])
//   res_valid_o  result offered to the consumer
//   res_ready_i  consumer accepts the result
//   busy_o       collecting words
//   short_o      sticky: done_i before all s words arrived
//   overrun_o    sticky: RES_push_i while not collecting
//   state_o      debug view of the FSM state
// ---------------------------------------------------------------------------
module fios_res_collector #(
    parameter int s = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              RES_push_i,
    input  logic [16:0]       RES_i,
    input  logic              done_i,
    input  logic [s*17-1:0]   p_i,
    output logic [s*17-1:0]   res_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              short_o,
    output logic              overrun_o,
    output logic [1:0]        state_o
);

    localparam int CW = $clog2(s + 1);
    localparam logic [CW-1:0] LAST = CW'(s - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_VALID   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [s*17-1:0] raw_q, raw_d;
    logic            short_q, short_d;
    logic            over_q, over_d;
    logic            word_we;
    logic            arm;

`ifdef FIOS_RES_SUB_EN
    logic [s*17-1:0] diff_q, diff_d;
    logic            borrow_q, borrow_d;
    logic [16:0]     p_word;
    logic [17:0]     diff;

    // Modulus word matching the slot being written.
    always_comb begin
        p_word = 17'd0;
        for (int k = 0; k < s; k++) begin
            if (cnt_q == CW'(k)) begin
                p_word = p_i[k*17 +: 17];
            end
        end
    end

    // Bit 17 of the 18-bit difference is the borrow out of this word.
    assign diff = {1'b0, RES_i} - {1'b0, p_word} - {17'd0, borrow_q};
`else
    logic unused_p;
    assign unused_p = ^p_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raw_d   = raw_q;
        short_d = short_q;
        over_d  = over_q;
        word_we = 1'b0;
        arm     = 1'b0;
`ifdef FIOS_RES_SUB_EN
        diff_d   = diff_q;
        borrow_d = borrow_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    arm     = 1'b1;
                    short_d = 1'b0;
                    over_d  = 1'b0;
                    state_d = ST_COLLECT;
                end else if (RES_push_i) begin
                    over_d = 1'b1;
                end
            end
            ST_COLLECT: begin
                // Restart wins over a coinciding push; that word is dropped.
                if (start_i) begin
                    arm = 1'b1;
                end else begin
                    if (RES_push_i) begin
                        word_we = 1'b1;
                        cnt_d   = cnt_q + CW'(1);
                    end
                    // done_i alongside the last push is the normal ending.
                    if (RES_push_i && cnt_q == LAST) begin
                        state_d = ST_VALID;
                    end else if (done_i) begin
                        short_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_VALID: begin
                if (RES_push_i) begin
                    over_d = 1'b1;
                end
                if (res_ready_i) begin
                    if (start_i) begin
                        arm     = 1'b1;
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int k = 0; k < s; k++) begin
            if (word_we && cnt_q == CW'(k)) begin
                raw_d[k*17 +: 17] = RES_i;
`ifdef FIOS_RES_SUB_EN
                diff_d[k*17 +: 17] = diff[16:0];
`endif
            end
        end
`ifdef FIOS_RES_SUB_EN
        if (word_we) begin
            borrow_d = diff[17];
        end
`endif

        if (arm) begin
            cnt_d = '0;
`ifdef FIOS_RES_SUB_EN
            borrow_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            raw_q   <= '0;
            short_q <= 1'b0;
            over_q  <= 1'b0;
`ifdef FIOS_RES_SUB_EN
            diff_q   <= '0;
            borrow_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raw_q   <= raw_d;
            short_q <= short_d;
            over_q  <= over_d;
`ifdef FIOS_RES_SUB_EN
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`endif
        end
    end

`ifdef FIOS_RES_SUB_EN
    // A final borrow means R < p, so the raw words are already reduced.
    assign res_o = borrow_q ? raw_q : diff_q;
`else
    assign res_o = raw_q;
`endif
    assign res_valid_o = (state_q == ST_VALID);
    assign busy_o      = (state_q == ST_COLLECT);
    assign short_o     = short_q;
    assign overrun_o   = over_q;
    assign state_o     = state_q;

endmodule
